// File: rtl/wbu_commit.sv
// Write-back stage: buffers load/store results in a small FIFO and retires one per granted cycle.
// Optional retired-instruction counter enabled by defining WBU_MINSTRET_EN.
module wbu_commit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             lsu_valid_i,
    input  logic [103:0]     lsu_data_i,
    output logic             wbu_ready_o,
    input  logic             rf_grant_i,
    output logic             rf_wen_o,
    output logic [4:0]       rf_waddr_o,
    output logic [WIDTH-1:0] rf_wdata_o,
    output logic             commit_o,
    output logic             halt_o,
    output logic [WIDTH-1:0] halt_code_o,
    output logic [63:0]      minstret_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] Full = CntW'(DEPTH);

    typedef enum logic [0:0] {StRun, StHalt} state_e;

    // mem_addr is not needed downstream, so only the low 72 payload bits are stored.
    logic [71:0]      mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    state_e           state_q, state_d;
    logic             rf_wen_q, rf_wen_d, commit_q, commit_d;
    logic [4:0]       rf_waddr_q, rf_waddr_d;
    logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d, halt_code_q, halt_code_d;
    logic             push, pop;
    logic [71:0]      head;
    logic             unused_mem_addr;

    assign unused_mem_addr = ^lsu_data_i[103:72];
    assign head            = mem_q[rd_ptr_q];

    assign wbu_ready_o = (count_q != Full) && (state_q == StRun);
    assign push        = lsu_valid_i && wbu_ready_o;
    assign pop         = (count_q != '0) && rf_grant_i && (state_q == StRun);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        rf_wen_d    = 1'b0;
        commit_d    = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        halt_code_d = halt_code_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d   = rd_ptr_q + PtrW'(1);
            rf_wen_d   = head[39] && (head[37:33] != 5'd0);
            rf_waddr_d = head[37:33];
            rf_wdata_d = head[38] ? head[71:40] : head[32:1];
            commit_d   = 1'b1;
            if (head[0]) begin
                state_d     = StHalt;
                halt_code_d = head[32:1];
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Once halted, anything left in the FIFO is dead.
        if (state_q == StHalt) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= StRun;
            rf_wen_q    <= 1'b0;
            commit_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            halt_code_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            rf_wen_q    <= rf_wen_d;
            commit_q    <= commit_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            halt_code_q <= halt_code_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= lsu_data_i[71:0];
        end
    end

`ifdef WBU_MINSTRET_EN
    logic [63:0] minstret_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            minstret_q <= '0;
        end else if (pop && (minstret_q != '1)) begin
            minstret_q <= minstret_q + 64'd1;
        end
    end

    assign minstret_o = minstret_q;
`else
    assign minstret_o = '0;
`endif

    assign rf_wen_o    = rf_wen_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign commit_o    = commit_q;
    assign halt_o      = (state_q == StHalt);
    assign halt_code_o = halt_code_q;

endmodule
